iram_fetch_unit: RTL
====================

# iram_fetch_unit

Parametrised instruction memory with an in-system program-load port and a registered fetch handshake. Replaces the fixed 8-bit/256-word instruction RAM: the control unit fetches through the same `FETCH`/`iAddr`/`instr` style interface, while a boot loader (e.g. UART receiver) streams the program in word by word before execution. It adds validity and bounds reporting that the fixed RAM lacks.

## Interface

Parameters:
- `INSTR_W`, 8: instruction word width in bits.
- `ADDR_W`, 8: fetch address width.
- `DEPTH`, 256: number of words. Must be ≤ 2^ADDR_W.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `loadStart`  in  1  begin a program load; clears the write pointer.
- `loadValid`  in  1  `loadData` is valid this cycle.
- `loadData`  in  INSTR_W  word to write at the current write pointer.
- `loadDone`  in  1  end of program load.
- `FETCH`  in  1  fetch request for `iAddr`.
- `iAddr`  in  ADDR_W  fetch address.
- `instr`  out  INSTR_W  fetched instruction, registered.
- `instrValid`  out  1  one-cycle pulse: `instr` updated by an accepted fetch.
- `fetchErr`  out  1  accompanies `instrValid`: address outside the loaded program.
- `ready`  out  1  high in RUN; fetches are accepted only while high.
- `loadCount`  out  ADDR_W+1  words written in the current/last load.
- `loadOvf`  out  1  sticky: a write was dropped because memory was full.

## Operation

- FSM states:
  - EMPTY: after reset.
  - LOAD: accepting words.
  - RUN: serving fetches.
- Transitions, evaluated at each edge in priority order:
  - `rst`: to EMPTY.
  - `loadStart` from any state: to LOAD, `loadCount`←0, `loadOvf`←0.
  - `loadDone` in LOAD: to RUN.
  - Otherwise hold.
  - `loadDone` outside LOAD is ignored.
- Load: in LOAD, `loadValid`=1 and `loadCount`<DEPTH writes `loadData` to word `loadCount`, then `loadCount`+1.
  - `loadValid` with `loadCount`==DEPTH: word dropped, `loadOvf`←1.
  - `loadValid` outside LOAD: ignored.
- Same-cycle load events:
  - `loadValid` with `loadDone`: the word is written and the FSM enters RUN.
  - `loadValid` with `loadStart`: the word is ignored.
- Fetch: in RUN, `FETCH`=1 is accepted.
  - `iAddr` < `loadCount`: `instr`←mem[`iAddr`], `fetchErr`←0.
  - Otherwise: `instr`←NOP (all zeros), `fetchErr`←1.
  - `FETCH` in EMPTY/LOAD: not accepted. `instrValid` stays 0 and `instr` holds.
- Zero-length load (`loadDone` with `loadCount`=0): RUN is entered and every fetch errors.
- Memory array is not reset. Reset mid-load leaves stale contents, but `loadCount`=0 makes them unreachable.

## Timing

- Reset values: `instr`=0, `instrValid`=0, `fetchErr`=0, `ready`=0, `loadCount`=0, `loadOvf`=0.
- Fetch latency is 1 cycle. `FETCH`/`iAddr` sampled at edge N gives `instr`, `instrValid`=1 and `fetchErr` valid after edge N; `instrValid` drops after N+1 unless `FETCH` is held.
- Back-to-back fetches: one per cycle, full throughput, no bubbles.
- `instr` holds its last value between accepted fetches. `fetchErr` is meaningful only when `instrValid`=1 and resets to 0 otherwise.
- `ready` rises the cycle after the edge that samples `loadDone`. A `FETCH` in that same edge is not accepted.
- Write takes effect at the edge it is sampled. A fetch of that address accepted at the next edge returns the new word; the fetch path is not accepted in LOAD anyway.
- `loadCount` is registered and updates at the write edge.

## Structure

- Package `iram_pkg`:
  - FSM state enum: EMPTY, LOAD, RUN.
  - `NOP` constant, parameterised to `INSTR_W` zeros.
- Sub-module `iram_array`: simple dual-port array (one synchronous write port, one synchronous read port), `DEPTH`×`INSTR_W`, no reset. The top holds the FSM, counters and output registers.

## Test plan

- Reset then `FETCH`=1, `iAddr`=0 for 5 cycles -> `instrValid`=0, `instr`=0, `ready`=0 throughout.
- `loadStart`, write 0x11,0x22,0x33,0x44, `loadDone`; fetch addresses 0..3 back-to-back -> `instr` 0x11,0x22,0x33,0x44 one cycle after each, `instrValid` high 4 cycles, `fetchErr`=0, `loadCount`=4.
- After that load, fetch `iAddr`=4 and `iAddr`=255 -> `instr`=0x00, `fetchErr`=1, `instrValid`=1 each.
- DEPTH=4 build: write 5 words -> `loadCount`=4, `loadOvf`=1, fetch 0..3 returns the first 4 words.
- `loadValid` with `loadDone` on word 3 (0xA5) -> address 2 reads 0xA5. `loadStart` with `loadDone` -> state LOAD, `ready`=0.
- Assert `rst` mid-load after 2 words, then `loadStart`, write 0x7E, `loadDone` -> `loadCount`=1, addr 0=0x7E, addr 1 gives `fetchErr`=1.

Source files
------------

// File: rtl/iram_pkg.sv
// Shared types and constants for the loadable instruction RAM.
package iram_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

  // Wide all-zero word; users narrow it with a width cast to their INSTR_W.
  localparam int unsigned NOP_MAX_W = 64;
  localparam logic [NOP_MAX_W-1:0] NOP = '0;

  function automatic int unsigned idx_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/iram_fetch_unit_if.sv
// Program-load and fetch bus between the loader/control unit and the instruction RAM.
interface iram_fetch_unit_if #(
  parameter int unsigned INSTR_W = 8,
  parameter int unsigned ADDR_W  = 8
);
  logic               loadStart;
  logic               loadValid;
  logic [INSTR_W-1:0] loadData;
  logic               loadDone;
  logic               FETCH;
  logic [ADDR_W-1:0]  iAddr;
  logic [INSTR_W-1:0] instr;
  logic               instrValid;
  logic               fetchErr;
  logic               ready;
  logic [ADDR_W:0]    loadCount;
  logic               loadOvf;

  modport master (
    output loadStart, loadValid, loadData, loadDone, FETCH, iAddr,
    input  instr, instrValid, fetchErr, ready, loadCount, loadOvf
  );

  modport slave (
    input  loadStart, loadValid, loadData, loadDone, FETCH, iAddr,
    output instr, instrValid, fetchErr, ready, loadCount, loadOvf
  );
endinterface

// File: rtl/iram_array.sv
// Simple dual-port storage: one synchronous write port, one synchronous read port, no reset.
module iram_array #(
  parameter int unsigned INSTR_W = 8,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned AW      = 8
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic               re,
  input  logic [AW-1:0]      raddr,
  output logic [INSTR_W-1:0] rdata
);
  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [INSTR_W-1:0] rdata_q;

  // Read register holds its value when no read is issued.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/iram_fetch_unit.sv
// Loadable instruction RAM: boot-loader write stream, registered fetch with bounds reporting.
module iram_fetch_unit
  import iram_pkg::*;
#(
  parameter int unsigned INSTR_W = 8,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DEPTH   = 256
) (
  input logic              clk,
  input logic              rst,
  iram_fetch_unit_if.slave bus
);
  localparam int unsigned AW = idx_w(DEPTH);
  localparam int unsigned CW = ADDR_W + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            ready_q, ready_d;
  logic            nop_q, nop_d;
  logic            accept_c, in_range_c, full_c, we_c, re_c;
  logic [INSTR_W-1:0] rdata;

  iram_array #(
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH),
    .AW      (AW)
  ) u_array (
    .clk   (clk),
    .we    (we_c),
    .waddr (cnt_q[AW-1:0]),
    .wdata (bus.loadData),
    .re    (re_c),
    .raddr (bus.iAddr[AW-1:0]),
    .rdata (rdata)
  );

  // Next-state, load counter and fetch response.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    nop_d   = nop_q;

    full_c     = (cnt_q == DEPTH_C);
    in_range_c = ({1'b0, bus.iAddr} < cnt_q);
    accept_c   = (state_q == RUN) && bus.FETCH;
    we_c       = (state_q == LOAD) && bus.loadValid && !bus.loadStart && !full_c;
    re_c       = accept_c && in_range_c;

    valid_d = accept_c;
    err_d   = accept_c && !in_range_c;
    if (accept_c) nop_d = !in_range_c;

    if (bus.loadStart) begin
      state_d = LOAD;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else if (state_q == LOAD) begin
      if (we_c) cnt_d = cnt_q + CW'(1);
      if (bus.loadValid && full_c) ovf_d = 1'b1;
      if (bus.loadDone) state_d = RUN;
    end

    ready_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      nop_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      nop_q   <= nop_d;
    end
  end

  // Error fetches (and reset) present NOP; the read register keeps the last good word.
  assign bus.instr      = nop_q ? INSTR_W'(NOP) : rdata;
  assign bus.instrValid = valid_q;
  assign bus.fetchErr   = err_q;
  assign bus.ready      = ready_q;
  assign bus.loadCount  = cnt_q;
  assign bus.loadOvf    = ovf_q;
endmodule
